// File: rtl/masked_serial_adder.sv
// Bit-serial 2-share masked ripple-carry adder: one masked full-adder step per
// accepted randomness transfer, LSB first, with carry shares registered between steps.
module masked_serial_adder #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b0,
    input  logic [W-1:0] b1,
    input  logic         cin0,
    input  logic         cin1,
    input  logic         rnd_valid,
    output logic         rnd_ready,
    input  logic [1:0]   rnd,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] s0,
    output logic [W-1:0] s1,
    output logic         cout0,
    output logic         cout1,
    output logic         busy
);
    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0] LAST = IW'(W - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;

    logic [W-1:0]  a0_sr, a1_sr, b0_sr, b1_sr;
    logic [W-1:0]  sum0_sr, sum1_sr;
    logic          c0, c1;
    logic [IW-1:0] idx;

    // Per-share step logic. Each share only meets the other share inside an
    // AND term that is immediately refreshed by a fresh random bit.
    logic x0, x1, y0, y1, p0, p1, sb0, sb1, g0, g1, t0, t1, nc0, nc1;
    always_comb begin
        x0  = a0_sr[0];
        x1  = a1_sr[0];
        y0  = b0_sr[0];
        y1  = b1_sr[0];
        p0  = x0 ^ y0;
        p1  = x1 ^ y1;
        sb0 = p0 ^ c0;
        sb1 = p1 ^ c1;
        g0  = (x0 & y0) ^ (x0 & y1) ^ rnd[0];
        g1  = (x1 & y1) ^ (x1 & y0) ^ rnd[0];
        t0  = (p0 & c0) ^ (p0 & c1) ^ rnd[1];
        t1  = (p1 & c1) ^ (p1 & c0) ^ rnd[1];
        nc0 = g0 ^ t0;
        nc1 = g1 ^ t1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            rnd_ready <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            s0        <= '0;
            s1        <= '0;
            cout0     <= 1'b0;
            cout1     <= 1'b0;
            idx       <= '0;
            c0        <= 1'b0;
            c1        <= 1'b0;
            a0_sr     <= '0;
            a1_sr     <= '0;
            b0_sr     <= '0;
            b1_sr     <= '0;
            sum0_sr   <= '0;
            sum1_sr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a0_sr     <= a0;
                        a1_sr     <= a1;
                        b0_sr     <= b0;
                        b1_sr     <= b1;
                        c0        <= cin0;
                        c1        <= cin1;
                        sum0_sr   <= '0;
                        sum1_sr   <= '0;
                        idx       <= '0;
                        state     <= RUN;
                        in_ready  <= 1'b0;
                        rnd_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (rnd_valid) begin
                        a0_sr   <= {1'b0, a0_sr[W-1:1]};
                        a1_sr   <= {1'b0, a1_sr[W-1:1]};
                        b0_sr   <= {1'b0, b0_sr[W-1:1]};
                        b1_sr   <= {1'b0, b1_sr[W-1:1]};
                        sum0_sr <= {sb0, sum0_sr[W-1:1]};
                        sum1_sr <= {sb1, sum1_sr[W-1:1]};
                        c0      <= nc0;
                        c1      <= nc1;
                        idx     <= idx + 1'b1;
                        if (idx == LAST) begin
                            s0        <= {sb0, sum0_sr[W-1:1]};
                            s1        <= {sb1, sum1_sr[W-1:1]};
                            cout0     <= nc0;
                            cout1     <= nc1;
                            state     <= DONE;
                            rnd_ready <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
